waiting_area_pax_counter: RTL
=============================

// Module: waiting_area_pax_counter
// PURPOSE
//  Upstream feeder for the airfield control block. Counts passengers in the terminal waiting area
//   from raw turnstile sensors (enter/exit), and subtracts a batch when a plane boards.
//  Produces the 6-bit passengers bus and a crowded flag consumed by the LED/runway controller.
//  Sensors are asynchronous mechanical contacts: synchronised and debounced here.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  consecutive stable synchronised samples required to accept a sensor level (>=2)
//  CAPACITY         60  crowded threshold; crowded=1 when passengers >= CAPACITY (<=63)
// PORTS
//  clk           in   1  system clock, all logic on posedge
//  rst           in   1  synchronous, active-high reset
//  enter_sensor  in   1  raw entry turnstile contact, async, active-high
//  exit_sensor   in   1  raw exit turnstile contact, async, active-high
//  board_req     in   1  boarding request, level, held until board_ack seen
//  board_count   in   6  passengers boarding; valid while board_req=1
//  board_ack     out  1  one-cycle acknowledge of a boarding request
//  passengers    out  6  current waiting-area count, 0..63
//  crowded       out  1  passengers >= CAPACITY (registered, same cycle as passengers)
//  count_err     out  1  sticky: an event was clipped by saturation at 0 or 63
// BEHAVIOUR
//  Reset: passengers=0, crowded=0, count_err=0, board_ack=0, sync/debounce state=0, FSM=IDLE.
//  Per sensor: 2-FF synchroniser -> debounce counter. A synced level differing from the accepted
//   level for DEBOUNCE_CYCLES consecutive cycles becomes the accepted level; any glitch back restarts.
//  Event pulse = one-cycle rising edge of accepted level. Falling edge produces no event.
//  Latency: raw sensor rises and stays high at edge N -> passengers updated at edge N+DEBOUNCE_CYCLES+3.
//  Boarding FSM:
//   IDLE: board_req=1 -> latch board_count as B, go ACK; B is applied in the same update as this cycle's events.
//   ACK: board_ack=1 for exactly this cycle; go WAIT_LOW.
//   WAIT_LOW: board_ack=0; board_req=0 -> IDLE. A req still high never re-triggers.
//  Count update (one per cycle, 8-bit signed arithmetic):
//   t = passengers - B(if latched this cycle, else 0) + enter_evt - exit_evt.
//   If t<0: passengers<=0, count_err<=1. If t>63: passengers<=63, count_err<=1. Else passengers<=t.
//  Simultaneous enter and exit events: net 0, no error.
//  Boarding more than present (B>passengers) clips to 0 and sets count_err.
//  count_err clears only on rst. crowded computed from next passengers value, registered with it.
//  rst mid-handshake: FSM->IDLE, board_ack=0. If board_req still high after rst, it is a new request.
//  rst while a sensor is held high: accepted level=0, so the held contact yields one event after debounce.
// CONFIGURATION
//  PAX_PEAK_HOLD_EN defined: adds output peak_pax[5:0] (reset 0), registered max of passengers since
//   rst, updates the same edge passengers first exceeds it.
//  Undefined: peak_pax port and logic absent; all other behaviour identical.
// TESTING  (DEBOUNCE_CYCLES=4, CAPACITY=60)
//  1. rst 2 cycles -> passengers=0, crowded=0, board_ack=0, count_err=0.
//  2. enter_sensor high 10 cycles, low 10, repeated 5x -> passengers=5; each update lands exactly 7 cycles after rise.
//  3. enter_sensor glitch high 3 cycles -> no count change; high 4+ cycles -> +1.
//  4. 60 enter pulses -> passengers=60, crowded=1 same cycle; 4 more -> 63, count_err=1.
//  5. passengers=10, board_req=1, board_count=4 held 6 cycles -> passengers=6 one edge after req sampled;
//     board_ack high one cycle only; no second decrement.
//  6. Same-cycle enter+exit events at passengers=0 -> stays 0, count_err=0; board_count=3 at 0 -> 0, count_err=1.

Source files
------------

// File: rtl/waiting_area_pax_counter_if.sv
// Boarding handshake between the airfield controller (master) and the waiting-area
// passenger counter (slave).
//   board_req   : level request, held by the master until board_ack is seen
//   board_count : passengers boarding, valid while board_req is high
//   board_ack   : one-cycle acknowledge from the counter
interface waiting_area_pax_counter_if;
  logic       board_req;
  logic [5:0] board_count;
  logic       board_ack;

  modport master (
    output board_req,
    output board_count,
    input  board_ack
  );

  modport slave (
    input  board_req,
    input  board_count,
    output board_ack
  );
endinterface

// File: rtl/waiting_area_pax_counter.sv
// Waiting-area passenger counter.
//
// Counts passengers from raw entry/exit turnstile contacts. Each contact is synchronised with
// two flops and debounced. A batch is subtracted when the boarding handshake fires. The count
// saturates at 0 and 63, and any clipped update sets a sticky error flag.
//
// Ports
//   clk          : system clock, posedge
//   rst          : synchronous active-high reset
//   enter_sensor : raw entry contact (asynchronous)
//   exit_sensor  : raw exit contact (asynchronous)
//   board_if     : boarding handshake (slave side: board_req/board_count in, board_ack out)
//   passengers   : current count, 0..63
//   crowded      : passengers >= CAPACITY, registered together with passengers
//   count_err    : sticky saturation flag, cleared only by rst
//   peak_pax     : highest count since rst (only with PAX_PEAK_HOLD_EN defined)
//
// Configuration macro: PAX_PEAK_HOLD_EN adds the peak_pax output and its register.
//
// Sensor-to-count latency: raw rise first sampled at edge N -> passengers updates at
// edge N + DEBOUNCE_CYCLES + 3 (2 sync stages, debounce, one registered edge pulse).
module waiting_area_pax_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CAPACITY        = 60
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enter_sensor,
  input  logic                              exit_sensor,
  waiting_area_pax_counter_if.slave         board_if,
  output logic [5:0]                        passengers,
  output logic                              crowded,
  output logic                              count_err
`ifdef PAX_PEAK_HOLD_EN
  ,
  output logic [5:0]                        peak_pax
`endif
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1; the next differing sample accepts.
  localparam int unsigned CntW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [5:0] CapLevel = 6'(CAPACITY);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StAck     = 2'd1;
  localparam logic [1:0] StWaitLow = 2'd2;

  // Bit 0 is the entry sensor, bit 1 the exit sensor.
  logic [1:0]           sync1_q, sync1_d;
  logic [1:0]           sync2_q, sync2_d;
  logic [1:0]           acc_q, acc_d;
  logic [1:0]           acc_dly_q, acc_dly_d;
  logic [1:0]           evt_q, evt_d;
  logic [1:0][CntW-1:0] cnt_q, cnt_d;

  logic [1:0] state_q, state_d;
  logic [5:0] pax_q, pax_d;
  logic       crowded_q, crowded_d;
  logic       err_q, err_d;

  logic        board_take;
  logic [5:0]  board_amt;
  logic signed [7:0] total;

  // --------------------------------------------------------------------------
  // Sensor synchronise + debounce + rising-edge event
  // --------------------------------------------------------------------------
  always_comb begin
    sync1_d   = {exit_sensor, enter_sensor};
    sync2_d   = sync1_q;
    acc_d     = acc_q;
    cnt_d     = '0;
    for (int i = 0; i < 2; i++) begin
      // Any sample agreeing with the accepted level restarts the count.
      if (sync2_q[i] != acc_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          acc_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    acc_dly_d = acc_q;
    // Only a rising accepted level counts; the falling edge is ignored.
    evt_d     = acc_q & ~acc_dly_q;
  end

  // --------------------------------------------------------------------------
  // Boarding handshake
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    board_take = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (board_if.board_req) begin
          board_take = 1'b1;
          state_d    = StAck;
        end
      end
      StAck: begin
        state_d = StWaitLow;
      end
      StWaitLow: begin
        // A request still held from the last handshake must drop before re-arming.
        if (!board_if.board_req) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign board_amt         = board_take ? board_if.board_count : 6'd0;
  assign board_if.board_ack = (state_q == StAck);

  // --------------------------------------------------------------------------
  // Count update with saturation
  // --------------------------------------------------------------------------
  always_comb begin
    total = $signed({2'b00, pax_q}) - $signed({2'b00, board_amt})
          + $signed({7'd0, evt_q[0]}) - $signed({7'd0, evt_q[1]});
    pax_d = pax_q;
    err_d = err_q;
    if (total < 8'sd0) begin
      pax_d = 6'd0;
      err_d = 1'b1;
    end else if (total > 8'sd63) begin
      pax_d = 6'd63;
      err_d = 1'b1;
    end else begin
      pax_d = total[5:0];
    end
    // Derived from the next count so crowded lines up with passengers.
    crowded_d = (pax_d >= CapLevel);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      acc_q     <= '0;
      acc_dly_q <= '0;
      evt_q     <= '0;
      cnt_q     <= '0;
      state_q   <= StIdle;
      pax_q     <= '0;
      crowded_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      acc_q     <= acc_d;
      acc_dly_q <= acc_dly_d;
      evt_q     <= evt_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      pax_q     <= pax_d;
      crowded_q <= crowded_d;
      err_q     <= err_d;
    end
  end

  assign passengers = pax_q;
  assign crowded    = crowded_q;
  assign count_err  = err_q;

`ifdef PAX_PEAK_HOLD_EN
  // --------------------------------------------------------------------------
  // Peak hold: follows the next count so it moves on the same edge
  // --------------------------------------------------------------------------
  logic [5:0] peak_q, peak_d;

  always_comb begin
    peak_d = (pax_d > peak_q) ? pax_d : peak_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_pax = peak_q;
`endif

endmodule
